// File: rtl/serial_word_comp_ctrl_pkg.sv
// Shared definitions for the bit-serial word comparator: FSM state encoding
// and a small decode helper used by the top level.
package serial_word_comp_ctrl_pkg;

  // 2'd3 is never entered; every decode treats it like IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_e;

  function automatic logic is_busy(input state_e s);
    return (s == ST_RUN) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/serial_word_comp_ctrl_bit_eq_cell.sv
// One-bit equality cell: op is high when both inputs carry the same value.
module bit_eq_cell (
  input  logic x,
  input  logic y,
  output logic op
);

  assign op = ~(x ^ y);

endmodule

// File: rtl/serial_word_comp_ctrl.sv
// Bit-serial magnitude/equality comparator: walks both operands MSB first
// through a single equality cell and reports eq/gt/lt with a done pulse.
module serial_word_comp_ctrl
  import serial_word_comp_ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [1:0]       dbg_state
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  // Handshake: start is sampled only while busy is low; a/b are captured on
  // that same edge and ignored at all other times. done is a one-cycle pulse
  // qualifying eq/gt/lt, which then stay valid until the next accepted start.

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               mis_q, mis_d;
  logic               gt_trk_q, gt_trk_d, lt_trk_q, lt_trk_d;
  logic               eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;

  logic bit_a, bit_b, bit_eq;
  logic first_mis, mis_nx, gt_nx, lt_nx, last_bit;

  assign bit_a = a_q[idx_q];
  assign bit_b = b_q[idx_q];

  bit_eq_cell u_cell (
    .x  (bit_a),
    .y  (bit_b),
    .op (bit_eq)
  );

  // Only the first differing bit decides the ordering; later bits are ignored.
  assign first_mis = ~bit_eq & ~mis_q;
  assign mis_nx    = mis_q | ~bit_eq;
  assign gt_nx     = first_mis ? bit_a : gt_trk_q;
  assign lt_nx     = first_mis ? bit_b : lt_trk_q;
  assign last_bit  = (idx_q == '0) || (EARLY_EXIT && mis_nx);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    mis_d    = mis_q;
    gt_trk_d = gt_trk_q;
    lt_trk_d = lt_trk_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    case (state_q)
      ST_RUN: begin
        mis_d    = mis_nx;
        gt_trk_d = gt_nx;
        lt_trk_d = lt_nx;
        if (abort) begin
          state_d = ST_IDLE;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
        end else if (last_bit) begin
          state_d = ST_DONE;
          eq_d    = ~mis_nx;
          gt_d    = gt_nx;
          lt_d    = lt_nx;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d  = ST_RUN;
          a_d      = a;
          b_d      = b;
          idx_d    = IDX_MSB;
          mis_d    = 1'b0;
          gt_trk_d = 1'b0;
          lt_trk_d = 1'b0;
          eq_d     = 1'b0;
          gt_d     = 1'b0;
          lt_d     = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      mis_q    <= 1'b0;
      gt_trk_q <= 1'b0;
      lt_trk_q <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      mis_q    <= mis_d;
      gt_trk_q <= gt_trk_d;
      lt_trk_q <= lt_trk_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
    end
  end

  assign busy      = is_busy(state_q);
  assign done      = (state_q == ST_DONE);
  assign eq        = eq_q;
  assign gt        = gt_q;
  assign lt        = lt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_word_comp_ctrl.sv
// Directed and randomized bench for serial_word_comp_ctrl at WIDTH=8, with one
// instance per EARLY_EXIT setting and a reference model built on plain arithmetic.
module tb_serial_word_comp_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start_s [2];
  logic         abort_s [2];
  logic [W-1:0] a_s     [2];
  logic [W-1:0] b_s     [2];
  logic         busy_o  [2];
  logic         done_o  [2];
  logic         eq_o    [2];
  logic         gt_o    [2];
  logic         lt_o    [2];
  logic [1:0]   dbg_o   [2];

  int checks;
  int failures;

  serial_word_comp_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_ee (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
    .a(a_s[0]), .b(b_s[0]), .busy(busy_o[0]), .done(done_o[0]),
    .eq(eq_o[0]), .gt(gt_o[0]), .lt(lt_o[0]), .dbg_state(dbg_o[0])
  );

  serial_word_comp_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_full (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
    .a(a_s[1]), .b(b_s[1]), .busy(busy_o[1]), .done(done_o[1]),
    .eq(eq_o[1]), .gt(gt_o[1]), .lt(lt_o[1]), .dbg_state(dbg_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edges after the accept edge until done is visible.
  function automatic int model_lat(input logic [W-1:0] x, input logic [W-1:0] y, input bit ee);
    int h;
    h = -1;
    for (int i = 0; i < W; i++) if (x[i] != y[i]) h = i;
    if (ee && h >= 0) return W - h;
    return W;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_results(input string tag, input int u, input logic e, input logic g, input logic l);
    check({tag, "_eq"}, 32'(eq_o[u]), 32'(e));
    check({tag, "_gt"}, 32'(gt_o[u]), 32'(g));
    check({tag, "_lt"}, 32'(lt_o[u]), 32'(l));
  endtask

  // Called at the negedge after the accept edge; returns edge count to done, or -1.
  task automatic wait_done(input int u, input bit glitch, input bit hold, output int k);
    k = -1;
    for (int i = 1; i <= 2 * W + 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_o[u]) begin
        k = i;
        break;
      end
      if (!hold) begin
        if (glitch && i == 1) begin
          start_s[u] = 1'b1;
          a_s[u] = 8'($urandom);
          b_s[u] = 8'($urandom);
        end else begin
          start_s[u] = 1'b0;
        end
      end
    end
    if (!hold) start_s[u] = 1'b0;
  endtask

  task automatic do_cmp(input int u, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit glitch, input bit abort_start, input bit abort_done);
    int lat, k;
    logic e, g, l;
    lat = model_lat(x, y, u == 0);
    e = (x == y);
    g = (x > y);
    l = (x < y);
    @(negedge clk);
    start_s[u] = 1'b1;
    abort_s[u] = abort_start;
    a_s[u] = x;
    b_s[u] = y;
    @(posedge clk);
    @(negedge clk);
    start_s[u] = 1'b0;
    abort_s[u] = 1'b0;
    a_s[u] = 8'($urandom);
    b_s[u] = 8'($urandom);
    check("accept_busy", 32'(busy_o[u]), 32'(1));
    check_results("accept_clear", u, 1'b0, 1'b0, 1'b0);
    wait_done(u, glitch, 1'b0, k);
    check("latency", 32'(k), 32'(lat));
    check("done_busy", 32'(busy_o[u]), 32'(1));
    check_results("result", u, e, g, l);
    if (abort_done) abort_s[u] = 1'b1;
    @(negedge clk);
    abort_s[u] = 1'b0;
    check("post_done", 32'(done_o[u]), 32'(0));
    check("post_busy", 32'(busy_o[u]), 32'(0));
    @(negedge clk);
    check("no_2nd_done", 32'(done_o[u]), 32'(0));
    check_results("held", u, e, g, l);
  endtask

  task automatic held_start(input int u, input logic [W-1:0] x1, input logic [W-1:0] y1,
                            input logic [W-1:0] x2, input logic [W-1:0] y2);
    int k;
    @(negedge clk);
    start_s[u] = 1'b1;
    a_s[u] = x1;
    b_s[u] = y1;
    @(posedge clk);
    @(negedge clk);
    a_s[u] = x2;
    b_s[u] = y2;
    wait_done(u, 1'b0, 1'b1, k);
    check("hold_lat1", 32'(k), 32'(model_lat(x1, y1, u == 0)));
    check_results("hold_res1", u, x1 == y1, x1 > y1, x1 < y1);
    @(negedge clk);
    check("hold_idle_gap", 32'(busy_o[u]), 32'(0));
    check_results("hold_res1_held", u, x1 == y1, x1 > y1, x1 < y1);
    @(posedge clk);
    @(negedge clk);
    start_s[u] = 1'b0;
    check("hold_accept2", 32'(busy_o[u]), 32'(1));
    check_results("hold_clear2", u, 1'b0, 1'b0, 1'b0);
    wait_done(u, 1'b0, 1'b0, k);
    check("hold_lat2", 32'(k), 32'(model_lat(x2, y2, u == 0)));
    check_results("hold_res2", u, x2 == y2, x2 > y2, x2 < y2);
    @(negedge clk);
  endtask

  // Abort is sampled on edge En after the accept edge.
  task automatic abort_test(input int u, input logic [W-1:0] x, input logic [W-1:0] y, input int n);
    bit seen;
    @(negedge clk);
    start_s[u] = 1'b1;
    a_s[u] = x;
    b_s[u] = y;
    @(posedge clk);
    @(negedge clk);
    start_s[u] = 1'b0;
    repeat (n - 1) begin
      @(posedge clk);
      @(negedge clk);
    end
    abort_s[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort_s[u] = 1'b0;
    check("abort_busy", 32'(busy_o[u]), 32'(0));
    check("abort_done", 32'(done_o[u]), 32'(0));
    check_results("abort_res", u, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    repeat (W + 2) begin
      @(negedge clk);
      if (done_o[u]) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'(0));
  endtask

  task automatic check_reset_state(input string tag);
    for (int u = 0; u < 2; u++) begin
      check({tag, "_busy"}, 32'(busy_o[u]), 32'(0));
      check({tag, "_done"}, 32'(done_o[u]), 32'(0));
      check({tag, "_state"}, 32'(dbg_o[u]), 32'(0));
      check_results(tag, u, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int ru;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start_s[u] = 1'b0;
      abort_s[u] = 1'b0;
      a_s[u] = '0;
      b_s[u] = '0;
    end
    #3;
    check_reset_state("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_cmp(0, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0);
    do_cmp(0, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0);
    do_cmp(1, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0);
    do_cmp(1, 8'h3C, 8'h3D, 1'b0, 1'b0, 1'b0);
    do_cmp(0, 8'h3C, 8'h3D, 1'b0, 1'b0, 1'b0);
    do_cmp(0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    do_cmp(1, 8'h12, 8'h34, 1'b1, 1'b0, 1'b0);
    do_cmp(0, 8'hF0, 8'h0F, 1'b1, 1'b0, 1'b0);
    do_cmp(0, 8'h55, 8'h54, 1'b0, 1'b1, 1'b0);
    do_cmp(1, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1);

    held_start(0, 8'hA5, 8'hA5, 8'h7F, 8'h80);
    held_start(1, 8'hC0, 8'h40, 8'h99, 8'h99);

    abort_test(1, 8'h12, 8'h34, 3);
    abort_test(0, 8'h5A, 8'h5A, 3);
    abort_test(1, 8'h77, 8'h76, W);
    abort_test(0, 8'hE1, 8'hE1, W);

    do_cmp(0, 8'h42, 8'h42, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start_s[1] = 1'b1;
    a_s[1] = 8'h9A;
    b_s[1] = 8'h9B;
    @(posedge clk);
    @(negedge clk);
    start_s[1] = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_cmp(1, 8'hC3, 8'h3C, 1'b0, 1'b0, 1'b0);
    do_cmp(0, 8'h0C, 8'h0D, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ru = $urandom_range(0, 1);
      ra = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ 8'(1 << $urandom_range(0, W - 1));
        default: rb = 8'($urandom);
      endcase
      do_cmp(ru, ra, rb, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
